// File: rtl/pipelined_cla_adder.sv
// ---------------------------------------------------------------------------
// pipelined_cla_adder
//
// Pipelined carry-lookahead adder. The WIDTH-bit operands are cut into
// GROUP-bit lookahead groups, and each group is resolved in its own pipeline
// stage. A stage only has to do the lookahead of one group, so the clock rate
// depends on GROUP and not on WIDTH. One add can start every cycle.
//
// The operands are captured in an input register. Stage k then adds group k,
// using the group carry that stage k-1 registered. Operand bits for later
// groups travel down the pipeline with the operation. Finished sum groups are
// also carried forward, so the whole of S reaches the output at the same time.
// Latency is NSTG = WIDTH/GROUP cycles, measured from the accepting edge.
//
// Optional feature macro: PCLA_SUB_EN
//   defined   : adds the 'sub' port. When sub=1 the block computes A + ~B + 1.
//   undefined : add only. There is no 'sub' port and no subtract logic.
//
// Ports
//   clk        in   clock; all state updates on the rising edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   operands presented this cycle
//   in_ready   out  operands are accepted this cycle (global enable)
//   A, B       in   WIDTH-bit operands
//   Cin        in   carry into bit 0
//   sub        in   subtract select (PCLA_SUB_EN only)
//   out_valid  out  S/Cout/Ovf hold a valid result
//   out_ready  in   downstream accepts the result this cycle
//   S          out  WIDTH-bit sum
//   Cout       out  carry out of bit WIDTH-1
//   Ovf        out  signed overflow (carry into MSB xor Cout)
// ---------------------------------------------------------------------------
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef PCLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             Ovf
);

    localparam int NSTG = WIDTH / GROUP;

    // Index k of each array is the register that feeds stage k.
    // Index NSTG of r_s, r_c and r_v is the output register.
    logic [WIDTH-1:0] r_a [NSTG];
    logic [WIDTH-1:0] r_b [NSTG];
    logic [WIDTH-1:0] r_s [NSTG+1];
    logic [NSTG:0]    r_c;
    logic [NSTG:0]    r_v;
    logic             r_ovf;

    logic             w_en;
    logic [WIDTH-1:0] w_bEff;
    logic             w_cinEff;
    logic [WIDTH-1:0] w_sum [NSTG];
    logic [NSTG-1:0]  w_cout;
    logic             w_cMsb;
    logic [GROUP-1:0] w_grpG;
    logic [GROUP-1:0] w_grpP;
    logic [GROUP:0]   w_grpC;

    // Full lookahead within one group. Each carry is a flat sum of products:
    // c[i+1] = G[i] | P[i]G[i-1] | ... | P[i..0]cin.
    // No carry waits on another carry, so the logic depth stays at two levels.
    function automatic logic [GROUP:0] groupCarries(
        input logic [GROUP-1:0] g,
        input logic [GROUP-1:0] p,
        input logic             cin
    );
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < GROUP; i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    // Subtraction becomes an add of ~B with a forced carry-in.
    // The effect of sub is captured in the input register together with the
    // operands, so it travels down the pipeline alongside them.
`ifdef PCLA_SUB_EN
    assign w_bEff   = sub ? ~B : B;
    assign w_cinEff = sub | Cin;
`else
    assign w_bEff   = B;
    assign w_cinEff = Cin;
`endif

    // A single global enable freezes the whole pipeline while a result waits
    // at the output. Bubbles wait on it too, so they never collapse.
    assign w_en      = !r_v[NSTG] | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_v[NSTG];
    assign S         = r_s[NSTG];
    assign Cout      = r_c[NSTG];
    assign Ovf       = r_ovf;

    // Stage k adds group k from its skewed operands and the registered group
    // carry. It merges the new sum group into the partial sum it forwards.
    // The carry into the MSB is taken from the last group, for overflow.
    always_comb begin
        w_grpG = '0;
        w_grpP = '0;
        w_grpC = '0;
        w_cout = '0;
        w_cMsb = 1'b0;
        for (int k = 0; k < NSTG; k++) begin
            w_sum[k] = '0;
        end
        for (int k = 0; k < NSTG; k++) begin
            w_grpG    = r_a[k][k*GROUP +: GROUP] & r_b[k][k*GROUP +: GROUP];
            w_grpP    = r_a[k][k*GROUP +: GROUP] ^ r_b[k][k*GROUP +: GROUP];
            w_grpC    = groupCarries(w_grpG, w_grpP, r_c[k]);
            w_sum[k]  = r_s[k];
            w_sum[k][k*GROUP +: GROUP] = w_grpP ^ w_grpC[GROUP-1:0];
            w_cout[k] = w_grpC[GROUP];
            if (k == NSTG - 1) begin
                w_cMsb = w_grpC[GROUP-1];
            end
        end
    end

    // Pipeline registers. Reset clears everything and wins over the enable.
    // Otherwise every stage, whether it holds data or a bubble, advances
    // together when the enable is high and holds when it is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
            end
            for (int k = 0; k <= NSTG; k++) begin
                r_s[k] <= '0;
            end
            r_c   <= '0;
            r_v   <= '0;
            r_ovf <= 1'b0;
        end else if (w_en) begin
            r_a[0] <= A;
            r_b[0] <= w_bEff;
            r_s[0] <= '0;
            r_c[0] <= w_cinEff;
            r_v[0] <= in_valid;
            for (int k = 1; k < NSTG; k++) begin
                r_a[k] <= r_a[k-1];
                r_b[k] <= r_b[k-1];
            end
            for (int k = 0; k < NSTG; k++) begin
                r_s[k+1] <= w_sum[k];
                r_c[k+1] <= w_cout[k];
                r_v[k+1] <= r_v[k];
            end
            r_ovf <= w_cMsb ^ w_cout[NSTG-1];
        end
    end

endmodule
